// File: rtl/game_timer_bcd_pkg.sv
// game_pkg: definitions shared by the game timer and the score block.
//   state_t    : game timer FSM states (ST_IDLE, ST_RUN, ST_DONE)
//   BCD_MAX    : largest legal BCD digit value
//   DIGIT_W    : bits per BCD digit
//   MAX_NDIGITS: widest BCD value any block in the datapath handles
//   BCD_W      : width of a full-size packed BCD value
//   REM_W      : binary width needed to hold 10**MAX_NDIGITS - 1
//   bcd_clamp  : forces a nibble into 0..9 (values above 9 become 9)
//   bcd2bin    : packed BCD (digit 0 in the LSB nibble) to binary
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam int         DIGIT_W     = 4;
  localparam int         MAX_NDIGITS = 4;
  localparam int         BCD_W       = DIGIT_W * MAX_NDIGITS;
  localparam int         REM_W       = 14;

  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

  // Horner evaluation from the most significant digit down, so the
  // conversion needs only a multiply-by-ten and an add per digit.
  function automatic logic [REM_W-1:0] bcd2bin(input logic [BCD_W-1:0] bcd);
    logic [REM_W-1:0] acc;
    acc = '0;
    for (int i = MAX_NDIGITS - 1; i >= 0; i--) begin
      acc = (acc * REM_W'(10)) + REM_W'(bcd[DIGIT_W*i +: DIGIT_W]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/game_timer_bcd_if.sv
// game_timer_bcd_if: control/status bundle of the game timer.
//   start      : 1-cycle pulse, load and (re)start a run
//   pause      : level, freeze count and prescaler
//   mode_down  : direction, sampled at start (1 = count down)
//   limit_bcd  : run length in BCD, sampled at start
//   digits_bcd : current value, digit 0 in the LSB nibble
//   tick       : 1-cycle pulse on each counted second
//   running    : timer is in RUN
//   warn       : running and few seconds remain
//   timeover   : sticky, the run reached its terminal value
// master drives the controls and reads status; slave is the timer.
interface game_timer_bcd_if #(
  parameter int NDIGITS = 2
);
  import game_pkg::*;

  logic                       start;
  logic                       pause;
  logic                       mode_down;
  logic [DIGIT_W*NDIGITS-1:0] limit_bcd;
  logic [DIGIT_W*NDIGITS-1:0] digits_bcd;
  logic                       tick;
  logic                       running;
  logic                       warn;
  logic                       timeover;

  modport master (
    output start, pause, mode_down, limit_bcd,
    input  digits_bcd, tick, running, warn, timeover
  );

  modport slave (
    input  start, pause, mode_down, limit_bcd,
    output digits_bcd, tick, running, warn, timeover
  );

endinterface

// File: rtl/game_timer_bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit of the game timer chain.
//   clk   : system clock
//   reset : asynchronous, active-low
//   en    : step this digit by one on the next edge
//   dir   : 0 = increment (9 -> 0), 1 = decrement (0 -> 9)
//   load  : load din (takes priority over en)
//   din   : value to load
//   q     : current digit, always 0..9
//   cout  : carry (up) or borrow (down) into the next digit
module bcd_digit_counter
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] q,
  output logic               cout
);

  // Carry/borrow is combinational so the whole chain steps on one edge:
  // a digit moves only when every lower digit is wrapping.
  assign cout = en && (dir ? (q == '0) : (q == BCD_MAX));

  // Digit register: load beats stepping, and wrapping keeps it in 0..9.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (en) begin
      if (dir) begin
        q <= (q == '0) ? BCD_MAX : q - 1'b1;
      end else begin
        q <= (q == BCD_MAX) ? '0 : q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_timer_bcd.sv
// game_timer_bcd: whole-second game clock counting up or down in packed BCD.
//   clk   : system clock, all logic on posedge
//   reset : asynchronous, active-low
//   bus   : game_timer_bcd_if slave (start/pause/mode_down/limit_bcd in,
//           digits_bcd/tick/running/warn/timeover out)
// Parameters: TICK_DIV clk cycles per second (>=2), NDIGITS BCD digits
// (1..4), WARN_SEC threshold for the warn flag.
module game_timer_bcd
  import game_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int NDIGITS  = 2,
  parameter int WARN_SEC = 10
) (
  input logic clk,
  input logic reset,
  game_timer_bcd_if.slave bus
);

  localparam int                PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int                VW         = DIGIT_W * NDIGITS;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [REM_W-1:0]  WARN_LIM   = REM_W'(WARN_SEC);

  state_t             state, state_next;
  logic [PW-1:0]      presc, presc_next;
  logic [REM_W-1:0]   remaining, remaining_next;
  logic               mode_lat;
  logic [VW-1:0]      lim_clean;
  logic [VW-1:0]      load_val;
  logic [VW-1:0]      digits;
  logic               step;
  logic               load;
  logic               tick_c;
  logic [NDIGITS:0]   en_chain;
  logic               unused_top_carry;

  // Limit digits above 9 are clamped before anything sees them, so the
  // digit chain and the remaining counter always agree.
  always_comb begin
    lim_clean = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      lim_clean[DIGIT_W*i +: DIGIT_W] = bcd_clamp(bus.limit_bcd[DIGIT_W*i +: DIGIT_W]);
    end
  end

  assign load_val = bus.mode_down ? lim_clean : '0;

  // State register, prescaler, remaining-seconds counter and the
  // direction latched at start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      presc     <= '0;
      remaining <= '0;
      mode_lat  <= 1'b0;
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      remaining <= remaining_next;
      if (bus.start) begin
        mode_lat <= bus.mode_down;
      end
    end
  end

  // Next-state logic. start beats everything, including a coincident
  // wrap. Termination is decided on the remaining count so up and down
  // runs share one rule; a zero-length run leaves RUN after one cycle
  // without ever ticking.
  always_comb begin
    state_next     = state;
    presc_next     = presc;
    remaining_next = remaining;
    step           = 1'b0;
    load           = 1'b0;
    tick_c         = 1'b0;
    if (bus.start) begin
      load           = 1'b1;
      state_next     = ST_RUN;
      presc_next     = '0;
      remaining_next = bcd2bin(BCD_W'(lim_clean));
    end else begin
      case (state)
        ST_RUN: begin
          if (remaining == '0) begin
            state_next = ST_DONE;
            presc_next = '0;
          end else if (!bus.pause) begin
            if (presc == PRESC_LAST) begin
              tick_c         = 1'b1;
              step           = 1'b1;
              presc_next     = '0;
              remaining_next = remaining - 1'b1;
              if (remaining == REM_W'(1)) begin
                state_next = ST_DONE;
              end
            end else begin
              presc_next = presc + 1'b1;
            end
          end
        end
        default: begin
          presc_next = '0;
        end
      endcase
    end
  end

  assign en_chain[0] = step;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk  (clk),
      .reset(reset),
      .en   (en_chain[g]),
      .dir  (mode_lat),
      .load (load),
      .din  (load_val[DIGIT_W*g +: DIGIT_W]),
      .q    (digits[DIGIT_W*g +: DIGIT_W]),
      .cout (en_chain[g+1])
    );
  end

  // The top digit's carry never matters: the terminal check stops the
  // count before it could wrap.
  assign unused_top_carry = en_chain[NDIGITS];

  assign bus.digits_bcd = digits;
  assign bus.tick       = tick_c;
  assign bus.running    = (state == ST_RUN);
  assign bus.timeover   = (state == ST_DONE);
  assign bus.warn       = (state == ST_RUN) && (remaining <= WARN_LIM);

endmodule
